ft_tx_arbiter: RTL and testbench
================================

FT_TX_ARBITER -- requirements
Module: ft_tx_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of byte-stream requesters (2..4).
REQ-002 SHALL have parameter MAX_BURST, default 64, max payload bytes per grant (1..255).
REQ-003 SHALL have port clk, input, 1, the single clock for all logic.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port req_valid, input, NREQ, requester i has a byte on req_data slice i.
REQ-006 SHALL have port req_data, input, 8*NREQ, requester bytes; byte i is bits [8i+7:8i].
REQ-007 SHALL have port req_last, input, NREQ, marks the last byte of the requester's burst.
REQ-008 SHALL have port req_ready, output, NREQ, byte i accepted this cycle when req_valid[i] and req_ready[i] are both high.
REQ-009 SHALL have port wr_en, output, 1, write strobe to FT2232H write FIFO.
REQ-010 SHALL have port wr_data, output, 8, byte to FT2232H write FIFO.
REQ-011 SHALL have port wr_full, input, 1, FT2232H write FIFO full.
REQ-012 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-013 SHALL have port grant_id, output, 2, index of the currently granted requester; holds its last value while in IDLE.

Function
REQ-014 SHALL implement FSM states IDLE, HDR, DATA.
REQ-015 In IDLE, any req_valid high SHALL cause grant of the first requester with req_valid high, searching round-robin from (last grant + 1) mod NREQ, and a move to HDR (header enabled) or DATA (header disabled).
REQ-016 HDR SHALL issue one byte {4'hA, 2'b00, grant_id} when wr_full is low, then move to DATA; it SHALL stall while wr_full is high.
REQ-017 req_ready[g] SHALL equal (state==DATA) AND (grant==g) AND NOT wr_full, combinationally; all other req_ready bits SHALL be 0.
REQ-018 Each accepted byte SHALL appear on wr_data with wr_en high exactly one cycle later; wr_en SHALL be 0 in all other cycles.
REQ-019 The burst counter SHALL count accepted bytes, with width clog2(MAX_BURST+1).
REQ-020 DATA SHALL return to IDLE after an accepted byte with req_last high, or after the MAX_BURST-th accepted byte, whichever comes first.
REQ-021 When the granted requester drops req_valid inside DATA, the FSM SHALL wait in DATA; there is no timeout.
REQ-022 If req_valid and wr_full are high in the same cycle, the byte SHALL NOT be accepted and no byte SHALL be lost or duplicated.
REQ-023 The round-robin pointer SHALL update only on grant, so a requester that is continuously requesting waits at most NREQ-1 bursts.

Reset
REQ-024 On rst_n low, asynchronously: state=IDLE, wr_en=0, wr_data=0, grant_id=0, last-grant pointer=NREQ-1, counter=0, busy=0.
REQ-025 Reset asserted mid-burst SHALL abort the burst with no further wr_en; after release, arbitration SHALL restart with requester 0 first.

Configuration
REQ-026 With macro FT_TX_ARB_HEADER_EN defined, the HDR state and header byte SHALL be compiled in.
REQ-027 Without FT_TX_ARB_HEADER_EN, HDR SHALL NOT exist and a grant SHALL go directly from IDLE to DATA.

Structure
REQ-028 Package ft_pkg SHALL hold: the state enum, the header nibble constant 4'hA, and the requester index constants REQ_ECHO=0, REQ_ADC=1, REQ_STAT=2.
REQ-029 Round-robin selection SHALL be one combinational sub-module, rr_pick (inputs: request vector, last-grant pointer; outputs: grant index, any-request flag).

Verification
REQ-030 Header enabled; req0 sends 3 bytes 0x71,0x72,0x73 (last on 0x73), wr_full=0 -> wr_data sequence 0xA0,0x71,0x72,0x73, with wr_en high on 4 consecutive cycles.
REQ-031 req0 and req1 valid from reset, each sending single-byte bursts 0x10 and 0x20 -> header-enabled stream alternates A0,10,A1,20,A0,10...
REQ-032 req1 streams 100 bytes with no req_last, MAX_BURST=64 -> 64 payload bytes, then return to IDLE, then regrant, then the remaining 36 bytes.
REQ-033 wr_full held high for 5 cycles mid-burst -> req_ready low and wr_en low during those cycles; byte order is intact and no duplicates appear.
REQ-034 rst_n pulsed low after 2 of 5 bytes -> wr_en low immediately; busy=0; after release, the next grant is requester 0.
REQ-035 Header disabled build; req2 sends 0x55 (last) -> single wr_en with 0x55 and no header byte.

Source files
------------

// File: rtl/ft_pkg.sv
// Shared types and constants for the FT2232H transmit arbiter.
// Optional feature macro: FT_TX_ARB_HEADER_EN (adds the HDR state and header byte).
package ft_pkg;

  // Arbiter FSM states; HDR only exists when the header feature is built in.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef FT_TX_ARB_HEADER_EN
    HDR  = 2'd1,
`endif
    DATA = 2'd2
  } state_t;

  // Upper nibble of every burst header byte.
  localparam logic [3:0] HDR_NIBBLE = 4'hA;

  // Requester slot assignment on the board.
  localparam int REQ_ECHO = 0;
  localparam int REQ_ADC  = 1;
  localparam int REQ_STAT = 2;

  // Header byte announcing which requester owns the following payload.
  function automatic logic [7:0] hdr_byte(input logic [1:0] id);
    return {HDR_NIBBLE, 2'b00, id};
  endfunction

endpackage

// File: rtl/ft_tx_arbiter_rr_pick.sv
// Combinational round-robin selector: finds the first active request
// starting one slot after the previous grant and wrapping modulo NREQ.
module rr_pick #(
  parameter int NREQ = 3
) (
  input  logic [NREQ-1:0] req,
  input  logic [1:0]      last,
  output logic [1:0]      idx,
  output logic            any
);

  logic [2:0] cand;

  // Scan from the farthest slot back to the nearest so the nearest hit wins.
  always_comb begin
    idx  = last;
    any  = 1'b0;
    cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      cand = {1'b0, last} + 3'(k);
      if (cand >= 3'(NREQ)) begin
        cand = cand - 3'(NREQ);
      end
      for (int j = 0; j < NREQ; j++) begin
        if (cand == 3'(j) && req[j]) begin
          idx = 2'(j);
          any = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/ft_tx_arbiter.sv
// Multiplexes NREQ byte streams into the FT2232H write FIFO, one burst per
// grant, with round-robin fairness and a registered write port.
// Optional feature macro: FT_TX_ARB_HEADER_EN (prefix each burst with a header byte).
module ft_tx_arbiter
  import ft_pkg::*;
#(
  parameter int NREQ      = 3,
  parameter int MAX_BURST = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic              wr_en,
  output logic [7:0]        wr_data,
  input  logic              wr_full,
  output logic              busy,
  output logic [1:0]        grant_id
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  state_t        state_reg, state_next;
  logic [1:0]    grant_reg;
  logic [1:0]    ptr_reg;
  logic [CW-1:0] cnt_reg;
  logic          wr_en_reg;
  logic [7:0]    wr_data_reg;

  logic [1:0]    pick_idx;
  logic          pick_any;
  logic          sel_valid;
  logic          sel_last;
  logic [7:0]    sel_data;
  logic          ready_base;
  logic          accept;
  logic          burst_end;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req  (req_valid),
    .last (ptr_reg),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // Route the granted requester's handshake signals.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_reg == 2'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[8*i +: 8];
      end
    end
  end

  assign accept    = (state_reg == DATA) && sel_valid && !wr_full;
  assign burst_end = accept && (sel_last || (cnt_reg == BURST_LAST));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic: grant, optional header, payload until last/limit.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (pick_any) begin
`ifdef FT_TX_ARB_HEADER_EN
          state_next = HDR;
`else
          state_next = DATA;
`endif
        end
      end
`ifdef FT_TX_ARB_HEADER_EN
      HDR: begin
        if (!wr_full) begin
          state_next = DATA;
        end
      end
`endif
      DATA: begin
        if (burst_end) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    busy       = (state_reg != IDLE);
    ready_base = (state_reg == DATA) && !wr_full;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_ready
      assign req_ready[gi] = ready_base && (grant_reg == 2'(gi));
    end
  endgenerate

  // Grant bookkeeping, burst counter and the one-cycle write pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_reg   <= '0;
      ptr_reg     <= 2'(NREQ - 1);
      cnt_reg     <= '0;
      wr_en_reg   <= 1'b0;
      wr_data_reg <= '0;
    end else begin
      wr_en_reg <= 1'b0;
      if (state_reg == IDLE && pick_any) begin
        grant_reg <= pick_idx;
        ptr_reg   <= pick_idx;
        cnt_reg   <= '0;
      end
`ifdef FT_TX_ARB_HEADER_EN
      if (state_reg == HDR && !wr_full) begin
        wr_en_reg   <= 1'b1;
        wr_data_reg <= hdr_byte(grant_reg);
      end
`endif
      if (accept) begin
        wr_en_reg   <= 1'b1;
        wr_data_reg <= sel_data;
        cnt_reg     <= cnt_reg + CW'(1);
      end
    end
  end

  assign wr_en    = wr_en_reg;
  assign wr_data  = wr_data_reg;
  assign grant_id = grant_reg;

endmodule

// File: tb/tb_ft_tx_arbiter.sv
// Scoreboard bench for ft_tx_arbiter: expected write bytes are queued as
// stimulus is issued; a monitor pops and compares on every wr_en.
// Builds with or without FT_TX_ARB_HEADER_EN.
module tb_ft_tx_arbiter;

  localparam int NREQ = 3;
`ifdef FT_TX_ARB_HEADER_EN
  localparam bit HDR_EN = 1'b1;
`else
  localparam bit HDR_EN = 1'b0;
`endif
  localparam int HOFF = HDR_EN ? 1 : 0;

  logic              clk;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic              wr_en;
  logic [7:0]        wr_data;
  logic              wr_full;
  logic              busy;
  logic [1:0]        grant_id;

  ft_tx_arbiter #(.NREQ(NREQ), .MAX_BURST(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_last  (req_last),
    .req_ready (req_ready),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .wr_full   (wr_full),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks = 0;
  int n_errors = 0;
  int pop_cnt  = 0;

  logic [7:0] exp_q[$];
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [NREQ-1:0] acc = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, expv);
    end
  endtask

  task automatic push_hdr(input int g);
    if (HDR_EN) exp_q.push_back({4'hA, 2'b00, 2'(g)});
  endtask

  // Requester models: present queue heads, retire what was accepted.
  initial begin
    forever begin
      @(negedge clk);
      if (acc[0] && q0.size() > 0) void'(q0.pop_front());
      if (acc[1] && q1.size() > 0) void'(q1.pop_front());
      if (acc[2] && q2.size() > 0) void'(q2.pop_front());
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      if (q0.size() > 0) begin req_valid[0] = 1'b1; req_data[7:0]   = q0[0][7:0]; req_last[0] = q0[0][8]; end
      if (q1.size() > 0) begin req_valid[1] = 1'b1; req_data[15:8]  = q1[0][7:0]; req_last[1] = q1[0][8]; end
      if (q2.size() > 0) begin req_valid[2] = 1'b1; req_data[23:16] = q2[0][7:0]; req_last[2] = q2[0][8]; end
      #1;
      acc = req_valid & req_ready;
    end
  end

  // Monitor: every write must match the head of the scoreboard.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (wr_en === 1'b1) begin
        n_checks++;
        pop_cnt++;
        if (exp_q.size() == 0) begin
          n_errors++;
          $display("FAIL wr_data: unexpected write %02h, expected no write", wr_data);
        end else begin
          e = exp_q.pop_front();
          if (wr_data !== e) begin
            n_errors++;
            $display("FAIL wr_data: got %02h, expected %02h", wr_data, e);
          end else begin
            $display("write %02h (expected %02h) grant=%0d", wr_data, e, grant_id);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    q0.delete(); q1.delete(); q2.delete();
    exp_q.delete();
    #1;
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_data", 32'(wr_data), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_grant_id", 32'(grant_id), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_empty(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(exp_q.size()), 0);
  endtask

  task automatic wait_pops(input int target, input int bound);
    int n = 0;
    while (pop_cnt < target && n < bound) begin
      @(negedge clk);
      n++;
    end
    check("pop_wait", 32'(pop_cnt >= target), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int base;
    rst_n     = 1'b0;
    wr_full   = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;

    // Single 3-byte burst from requester 0, back-to-back writes.
    do_reset();
    q0.push_back({1'b0, 8'h71}); q0.push_back({1'b0, 8'h72}); q0.push_back({1'b1, 8'h73});
    push_hdr(0); exp_q.push_back(8'h71); exp_q.push_back(8'h72); exp_q.push_back(8'h73);
    n = 0;
    while (wr_en !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("t1_first_wr_en", 32'(wr_en), 1);
    for (int k = 1; k < HOFF + 3; k++) begin
      @(negedge clk);
      check("t1_consecutive_wr_en", 32'(wr_en), 1);
    end
    @(negedge clk);
    check("t1_wr_en_after", 32'(wr_en), 0);
    check("t1_busy_idle", 32'(busy), 0);
    check("t1_grant_id", 32'(grant_id), 0);
    wait_empty("t1_drain", 20);

    // Two requesters with single-byte bursts alternate.
    do_reset();
    for (int k = 0; k < 3; k++) begin
      q0.push_back({1'b1, 8'h10});
      q1.push_back({1'b1, 8'h20});
      push_hdr(0); exp_q.push_back(8'h10);
      push_hdr(1); exp_q.push_back(8'h20);
    end
    wait_empty("t2_drain", 200);

    // 100 unterminated bytes: 64-byte burst limit, regrant, remainder.
    do_reset();
    for (int k = 0; k < 100; k++) q1.push_back({1'b0, 8'(k)});
    push_hdr(1);
    for (int k = 0; k < 64; k++) exp_q.push_back(8'(k));
    push_hdr(1);
    for (int k = 64; k < 100; k++) exp_q.push_back(8'(k));
    wait_empty("t3_drain", 400);
    repeat (5) @(negedge clk);
    check("t3_busy_waiting", 32'(busy), 1);
    check("t3_grant_id", 32'(grant_id), 1);

    // Write FIFO full for 5 cycles mid-burst.
    do_reset();
    base = pop_cnt;
    for (int k = 0; k < 8; k++) q0.push_back({(k == 7), 8'(8'h30 + k)});
    push_hdr(0);
    for (int k = 0; k < 8; k++) exp_q.push_back(8'(8'h30 + k));
    wait_pops(base + HOFF + 3, 100);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      wr_full = 1'b1;
      #1;
      check("t4_ready_full", 32'(req_ready), 0);
      if (k > 0) check("t4_wr_en_full", 32'(wr_en), 0);
    end
    @(negedge clk);
    check("t4_wr_en_full_last", 32'(wr_en), 0);
    wr_full = 1'b0;
    wait_empty("t4_drain", 100);
    repeat (3) @(negedge clk);
    check("t4_busy_idle", 32'(busy), 0);

    // Reset mid-burst, then requester 0 wins the next arbitration.
    do_reset();
    base = pop_cnt;
    for (int k = 0; k < 5; k++) q0.push_back({(k == 4), 8'(8'h41 + k)});
    push_hdr(0);
    for (int k = 0; k < 5; k++) exp_q.push_back(8'(8'h41 + k));
    wait_pops(base + HOFF + 2, 100);
    do_reset();
    q0.push_back({1'b1, 8'h77});
    q1.push_back({1'b1, 8'h66});
    push_hdr(0); exp_q.push_back(8'h77);
    push_hdr(1); exp_q.push_back(8'h66);
    wait_empty("t5_drain", 100);

    // Requester 2 single byte.
    do_reset();
    q2.push_back({1'b1, 8'h55});
    push_hdr(2); exp_q.push_back(8'h55);
    wait_empty("t6_drain", 50);
    repeat (3) @(negedge clk);
    check("t6_grant_id", 32'(grant_id), 2);
    check("t6_busy_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
